// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
//   Round-robin arbiter that shares one APB master port between N_REQ
//   requesters. A requester posts a command (req_valid/write/addr/wdata)
//   and holds it until its one-cycle req_done pulse. The arbiter runs the
//   APB SETUP/ACCESS phases, waits on PREADY and returns PRDATA/PSLVERR on
//   rsp_rdata/rsp_err alongside req_done. All outputs are registered.
//
// Ports
//   PCLK, PRESET          clock, synchronous active-high reset
//   req_valid/req_write   per-requester command pending / direction
//   req_addr/req_wdata    packed per-requester address and write data
//   req_done              one-hot completion pulse
//   rsp_rdata/rsp_err     completion data/error, valid with req_done
//   PADDR..PENABLE        APB master request signals
//   PREADY/PRDATA/PSLVERR APB slave response signals
//
// Optional feature
//   APB_ARB_TIMEOUT_EN    when defined, an ACCESS phase stalled for TIMEOUT
//                         cycles is aborted and completed with rsp_err=1.

module apb_master_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned APB_ADDR_WIDTH = 16,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic                               PCLK,
    input  logic                               PRESET,
    input  logic [N_REQ-1:0]                   req_valid,
    input  logic [N_REQ-1:0]                   req_write,
    input  logic [N_REQ*APB_ADDR_WIDTH-1:0]    req_addr,
    input  logic [N_REQ*APB_DATA_WIDTH-1:0]    req_wdata,
    output logic [N_REQ-1:0]                   req_done,
    output logic [APB_DATA_WIDTH-1:0]          rsp_rdata,
    output logic                               rsp_err,
    output logic [APB_ADDR_WIDTH-1:0]          PADDR,
    output logic                               PWRITE,
    output logic [APB_DATA_WIDTH-1:0]          PWDATA,
    output logic                               PSEL,
    output logic                               PENABLE,
    input  logic                               PREADY,
    input  logic [APB_DATA_WIDTH-1:0]          PRDATA,
    input  logic                               PSLVERR
);

    localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 16 || TIMEOUT < 1) begin : g_bad_param
        $error("apb_master_arbiter: N_REQ must be 2..16 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic [GW-1:0]                last_grant_q, last_grant_d;
    logic                         psel_q, psel_d;
    logic                         penable_q, penable_d;
    logic                         pwrite_q, pwrite_d;
    logic [APB_ADDR_WIDTH-1:0]    paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0]    pwdata_q, pwdata_d;
    logic [N_REQ-1:0]             done_q, done_d;
    logic [APB_DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                         err_q, err_d;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TOW-1:0]               to_cnt_q, to_cnt_d;
`endif

    // Round-robin pick. The request vector is rotated so that the requester
    // after last_grant sits at bit 0; the lowest set bit of the rotated
    // vector is the winner, and its offset is mapped back to an index.
    logic [N_REQ-1:0]             rr_win;
    logic                         arb_found;
    logic [GW-1:0]                arb_idx;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        rr_win    = N_REQ'({req_valid, req_valid} >> (32'(last_grant_q) + 32'd1));
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!arb_found && rr_win[j]) begin
                arb_found = 1'b1;
                arb_idx   = GW'((32'(last_grant_q) + 32'd1 + j) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        done_d       = '0;
        rdata_d      = rdata_q;
        err_d        = err_q;
`ifdef APB_ARB_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    // Command is captured here so the APB signals stay stable
                    // even if the requester changes its inputs afterwards.
                    state_d      = ST_SETUP;
                    last_grant_d = arb_idx;
                    psel_d       = 1'b1;
                    pwrite_d     = req_write[arb_idx];
                    paddr_d      = req_addr[arb_idx*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                    pwdata_d     = req_wdata[arb_idx*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                end
            end

            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                to_cnt_d  = '0;
`endif
            end

            ST_ACCESS: begin
                if (PREADY) begin
                    state_d   = ST_IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (!pwrite_q) begin
                        rdata_d = PRDATA;
                    end
                    err_d                = PSLVERR;
                    done_d[last_grant_q] = 1'b1;
                end
`ifdef APB_ARB_TIMEOUT_EN
                // PREADY is checked first so a response arriving on the
                // limit cycle still completes normally.
                else if (to_cnt_q == TOW'(TIMEOUT)) begin
                    state_d              = ST_IDLE;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    rdata_d              = '0;
                    err_d                = 1'b1;
                    done_d[last_grant_q] = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GW'(N_REQ - 1);
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            done_q       <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
`ifdef APB_ARB_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign req_done  = done_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Round-robin arbiter that shares a single APB master port between `N_REQ` internal requesters. Each requester posts one read or write command and holds it until a completion pulse. The arbiter sequences the APB SETUP/ACCESS phases, waits on `PREADY`, and returns `PRDATA`/`PSLVERR` to the granted requester. It sits between bus-master agents (DMA, CPU bridge, test sequencers) and an APB fabric built on the `apb_if` master modport signal set.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..16)
- `APB_ADDR_WIDTH`, 16, APB address width
- `APB_DATA_WIDTH`, 32, APB data width
- `TIMEOUT`, 255, maximum ACCESS-phase cycles before abort; used only with `APB_ARB_TIMEOUT_EN`

Ports:
- `PCLK`  in  1  single clock; all logic on rising edge
- `PRESET`  in  1  reset, synchronous, active-high
- `req_valid`  in  N_REQ  per-requester command pending
- `req_write`  in  N_REQ  1 = write, 0 = read
- `req_addr`  in  N_REQ*APB_ADDR_WIDTH  packed addresses, requester i at slice i
- `req_wdata`  in  N_REQ*APB_DATA_WIDTH  packed write data
- `req_done`  out  N_REQ  one-cycle completion pulse, one-hot
- `rsp_rdata`  out  APB_DATA_WIDTH  read data; valid when any `req_done` bit is 1
- `rsp_err`  out  1  slave error or timeout; valid when any `req_done` bit is 1
- `PADDR`  out  APB_ADDR_WIDTH  APB address
- `PWRITE`  out  1  APB direction
- `PWDATA`  out  APB_DATA_WIDTH  APB write data
- `PSEL`  out  1  APB select
- `PENABLE`  out  1  APB enable
- `PREADY`  in  1  APB ready
- `PRDATA`  in  APB_DATA_WIDTH  APB read data
- `PSLVERR`  in  1  APB slave error

## Operation
- State machine: IDLE, SETUP, ACCESS. All outputs are registered.
- **IDLE:**
  - If `req_valid` is nonzero, grant the first set bit at or after `(last_grant+1) mod N_REQ`, wrapping around.
  - Latch that requester's write, addr and wdata into the APB output registers, set `PSEL`=1, update `last_grant`, and go to SETUP.
- **SETUP:** set `PENABLE`=1 and go to ACCESS.
- **ACCESS:** when `PREADY`=1 is sampled:
  - Clear `PSEL` and `PENABLE`.
  - Register `PRDATA` into `rsp_rdata` for reads; leave `rsp_rdata` unchanged for writes.
  - Register `PSLVERR` into `rsp_err`.
  - Pulse `req_done[grant]` and return to IDLE.
- APB outputs are stable from SETUP until the end of ACCESS, because the command is latched at grant. A requester dropping `req_valid` after grant does not cancel the transfer.
- A requester must hold `req_valid` until its `req_done`. It may reassert `req_valid` in the cycle after `req_done`.
- Fairness: the requester just served has lowest priority at the next arbitration.

## Timing
- Reset values:
  - `PSEL`=0, `PENABLE`=0, `PWRITE`=0, `PADDR`=0, `PWDATA`=0
  - `req_done`=0, `rsp_rdata`=0, `rsp_err`=0
  - state=IDLE, `last_grant`=N_REQ-1, so requester 0 wins first
- Latencies:
  - `req_valid` sampled in IDLE → `PSEL`=1 at the next edge.
  - `PENABLE`=1 one cycle later.
  - `PREADY` sampled high → `req_done`, `PSEL`=0 and `PENABLE`=0 at the next edge.
- Zero-wait slave: a transfer takes 3 cycles. Back-to-back transfers repeat every 3 cycles, because IDLE coincides with the `req_done` cycle and `PSEL` is low for exactly one cycle between transfers.
- `req_done` is high for exactly one cycle. `rsp_rdata`/`rsp_err` hold their values until the next completion.
- Simultaneous requests: arbitration happens only in IDLE. Requests arriving during SETUP/ACCESS wait.
- Reset in any state: return to reset values at that edge. No `req_done` is issued for the aborted transfer.

## Configuration
- Macro: `APB_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter (width clog2(TIMEOUT+1)) clears on entry to ACCESS and increments each ACCESS cycle with `PREADY`=0.
  - When it reaches `TIMEOUT`, the next edge clears `PSEL`/`PENABLE`, pulses `req_done[grant]` with `rsp_err`=1 and `rsp_rdata`=0, and returns to IDLE.
  - `PREADY` asserted in the same cycle the limit is reached wins: normal completion.
- **Undefined:** no counter exists. ACCESS waits indefinitely for `PREADY`.

## Test plan
- Reset, then requester 2 writes addr 0x0010, data 0xDEADBEEF with zero-wait `PREADY` → `PSEL` high 2 cycles, `PENABLE` high 1 cycle, `req_done`=4'b0100 three cycles after `req_valid`, `rsp_err`=0.
- Requester 0 reads 0x0020; slave returns `PRDATA`=0x12345678 after 3 wait states → `req_done[0]` pulses 1 cycle after `PREADY`, `rsp_rdata`=0x12345678.
- All 4 requesters assert `req_valid` continuously after reset → grant order 0,1,2,3,0, with one transfer every 3 cycles.
- Slave returns `PSLVERR`=1 on a read by requester 1 → `req_done[1]`, `rsp_err`=1.
- `PRESET` asserted during ACCESS → `PSEL`=`PENABLE`=0 at the next edge and no `req_done`; the next grant goes to requester 0.
- With `APB_ARB_TIMEOUT_EN` and `TIMEOUT`=8, `PREADY` held low → abort with `req_done` and `rsp_err`=1, `rsp_rdata`=0 after 8 stalled ACCESS cycles.
